// File: rtl/mnist_pkg.sv
// mnist_pkg: shared sizes, assembly state encoding and label one-hot helper.
package mnist_pkg;
    localparam int N_PIX = 784;
    localparam int N_CLASS = 10;
    localparam int IMG_W = N_PIX + N_CLASS;
    localparam int LABEL_LSB = 0;
    localparam int PIX_LSB = 10;
    typedef enum logic [1:0] {LABEL, PIXELS, FULL, DISCARD} asm_state_e;
    function automatic logic [N_CLASS-1:0] onehot(input logic [3:0] l);
        return N_CLASS'(1) << l;
    endfunction
endpackage

// File: rtl/mnist_sample_packer_if.sv
// mnist_sample_packer_if: byte stream in, presented sample word and status out.
interface mnist_sample_packer_if;
    import mnist_pkg::*;
    logic [7:0] bin_thresh;
    logic s_valid;
    logic s_ready;
    logic [7:0] s_data;
    logic s_last;
    logic [IMG_W-1:0] image_data;
    logic present;
    logic [3:0] label_out;
    logic [15:0] sample_count;
    logic frame_err;
    modport master(output bin_thresh, s_valid, s_data, s_last,
                   input s_ready, image_data, present, label_out, sample_count, frame_err);
    modport slave(input bin_thresh, s_valid, s_data, s_last,
                  output s_ready, image_data, present, label_out, sample_count, frame_err);
endinterface

// File: rtl/mnist_frame_asm.sv
// mnist_frame_asm: frame parser, pixel binariser and 784-bit assembly buffer.
module mnist_frame_asm import mnist_pkg::*; (
    input  logic clk,
    input  logic rst,
    input  logic valid_i,
    input  logic last_i,
    input  logic [7:0] data_i,
    input  logic [7:0] thresh_i,
    input  logic take_i,
    output logic ready_o,
    output logic full_o,
    output logic err_o,
    output logic [N_PIX-1:0] pix_o,
    output logic [3:0] label_o
);
    asm_state_e state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [3:0] label_q, label_d;
    logic err_q, err_d;
    logic [N_PIX-1:0] buf_q;
    logic acc, end_pix;
    assign ready_o = !rst && state_q != FULL;
    assign acc = valid_i && ready_o;
    assign end_pix = cnt_q == 10'(N_PIX - 1);
    assign full_o = state_q == FULL;
    assign err_o = err_q;
    assign pix_o = buf_q;
    assign label_o = label_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LABEL;
            cnt_q <= '0;
            label_q <= '0;
            err_q <= 1'b0;
            buf_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            label_q <= label_d;
            err_q <= err_d;
            if (acc && state_q == PIXELS) buf_q[cnt_q] <= data_i > thresh_i;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        label_d = label_q;
        err_d = err_q;
        case (state_q)
            LABEL: if (acc) begin
                // a bad label, or a frame that ends on its label, both leave a malformed frame
                if (data_i > 8'd9 || last_i) begin
                    err_d = 1'b1;
                    state_d = last_i ? LABEL : DISCARD;
                end else begin
                    label_d = data_i[3:0];
                    cnt_d = '0;
                    state_d = PIXELS;
                end
            end
            PIXELS: if (acc) begin
                cnt_d = cnt_q + 10'd1;
                if (last_i) begin
                    err_d = err_q | !end_pix;
                    state_d = end_pix ? FULL : LABEL;
                end else if (end_pix) begin
                    err_d = 1'b1;
                    state_d = DISCARD;
                end
            end
            FULL: if (take_i) state_d = LABEL;
            default: if (acc && last_i) state_d = LABEL;
        endcase
    end
endmodule

// File: rtl/mnist_sample_packer.sv
// mnist_sample_packer: assembles binarised MNIST frames and presents each sample
// for PRESENT_CYCLES cycles, driving an all-zero word between samples.
module mnist_sample_packer import mnist_pkg::*; #(
    parameter int PRESENT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    mnist_sample_packer_if.slave bus
);
    localparam int HW = $clog2(PRESENT_CYCLES + 1);
    logic full, take;
    logic [N_PIX-1:0] pix;
    logic [3:0] label;
    logic [HW-1:0] hold_q, hold_d;
    logic [IMG_W-1:0] img_q, img_d;
    logic [3:0] lbl_q, lbl_d;
    logic [15:0] cnt_q, cnt_d;
    mnist_frame_asm u_asm (
        .clk(clk), .rst(rst),
        .valid_i(bus.s_valid), .last_i(bus.s_last), .data_i(bus.s_data), .thresh_i(bus.bin_thresh),
        .take_i(take), .ready_o(bus.s_ready), .full_o(full), .err_o(bus.frame_err),
        .pix_o(pix), .label_o(label)
    );
    // taking on the final hold cycle keeps back-to-back samples gapless
    assign take = full && hold_q <= HW'(1);
    always_comb begin
        hold_d = take ? HW'(PRESENT_CYCLES) : hold_q - HW'(hold_q != '0);
        img_d = hold_q == HW'(1) ? '0 : img_q;
        lbl_d = hold_q == HW'(1) ? 4'd0 : lbl_q;
        cnt_d = cnt_q + 16'(take);
        if (take) begin
            img_d = '0;
            img_d[PIX_LSB +: N_PIX] = pix;
            img_d[LABEL_LSB +: N_CLASS] = onehot(label);
            lbl_d = label;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            img_q <= '0;
            lbl_q <= '0;
            cnt_q <= '0;
        end else begin
            hold_q <= hold_d;
            img_q <= img_d;
            lbl_q <= lbl_d;
            cnt_q <= cnt_d;
        end
    end
    assign bus.image_data = img_q;
    assign bus.present = hold_q != '0;
    assign bus.label_out = lbl_q;
    assign bus.sample_count = cnt_q;
endmodule

// File: tb/tb_mnist_sample_packer.sv
// tb_mnist_sample_packer: table-driven frames with a sample scoreboard on two
// instances (single-cycle and long hold) sharing one stream driver.
module tb_mnist_sample_packer;
    localparam int P2 = 800;
    typedef struct {logic [793:0] img; logic [3:0] lbl;} exp_t;
    typedef struct {logic [7:0] lab; logic [7:0] th; int kind; int nb; int lastpos; bit ok; bit err;} vec_t;
    logic clk = 1'b0;
    logic rst, sel, v, l;
    logic [7:0] d, th;
    logic rdy, pres, ferr;
    logic [793:0] img;
    logic [3:0] lbo;
    logic [15:0] cnt_o, prev_cnt;
    int checks = 0, errors = 0, run = 0, last_run = 0, exp_cnt;
    exp_t q[$];
    exp_t x;
    vec_t tv[12];
    mnist_sample_packer_if if1();
    mnist_sample_packer_if if2();
    mnist_sample_packer #(.PRESENT_CYCLES(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    mnist_sample_packer #(.PRESENT_CYCLES(P2)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
    always #5 clk = ~clk;
    assign if1.s_valid = v && !sel;
    assign if2.s_valid = v && sel;
    assign if1.s_data = d;
    assign if2.s_data = d;
    assign if1.s_last = l;
    assign if2.s_last = l;
    assign if1.bin_thresh = th;
    assign if2.bin_thresh = th;
    assign rdy = sel ? if2.s_ready : if1.s_ready;
    assign pres = sel ? if2.present : if1.present;
    assign ferr = sel ? if2.frame_err : if1.frame_err;
    assign img = sel ? if2.image_data : if1.image_data;
    assign lbo = sel ? if2.label_out : if1.label_out;
    assign cnt_o = sel ? if2.sample_count : if1.sample_count;

    task automatic chk(input string n, input longint a, input longint e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    function automatic logic [7:0] pixv(input int kind, input int m, input logic [7:0] t);
        case (kind)
            0: return (m % 2 == 1) ? 8'd127 : 8'd128;
            2: return t;
            3: return 8'd255;
            default: return 8'((m * 37 + 11) % 256);
        endcase
    endfunction

    function automatic logic [7:0] thr(input int kind, input int m, input logic [7:0] t);
        return (kind == 4 && m >= 400) ? 8'd50 : t;
    endfunction

    task automatic beat(input logic [7:0] x, input logic lst);
        int w = 0;
        d = x; l = lst; v = 1'b1;
        while (!rdy && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (!rdy) begin
            errors++;
            $display("FAIL beat_timeout: s_ready stuck at %0d for %0d cycles", rdy, w);
        end
        @(posedge clk); #1;
        v = 1'b0; l = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] lab, input logic [7:0] t, input int kind,
                              input int nb, input int lastpos, input bit ok);
        exp_t e;
        e.img = '0;
        e.lbl = lab[3:0];
        for (int m = 0; m < 784; m++) e.img[10 + m] = pixv(kind, m, t) > thr(kind, m, t);
        if (ok) e.img[lab] = 1'b1;
        for (int b = 0; b < nb; b++) begin
            th = (b == 0) ? t : thr(kind, b - 1, t);
            beat((b == 0) ? lab : pixv(kind, b - 1, t), b == lastpos);
        end
        if (ok) q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (pres && cnt_o != prev_cnt) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_empty: sample %0d presented with none expected", cnt_o);
            end else begin
                x = q.pop_front();
                checks++;
                if (img !== x.img) begin
                    errors++;
                    $display("FAIL sb_img: got %h expected %h", img, x.img);
                end
                chk("sb_label", lbo, x.lbl);
            end
        end
        if (pres) run++;
        else begin
            if (run != 0) last_run = run;
            run = 0;
        end
        prev_cnt = cnt_o;
    end

    initial begin
        tv[0]  = '{8'd0,  8'd200, 1, 785, 784, 1'b1, 1'b0};
        tv[1]  = '{8'd9,  8'd0,   2, 785, 784, 1'b1, 1'b0};
        tv[2]  = '{8'd5,  8'd255, 3, 785, 784, 1'b1, 1'b0};
        tv[3]  = '{8'd1,  8'd254, 3, 785, 784, 1'b1, 1'b0};
        tv[4]  = '{8'd4,  8'd60,  4, 785, 784, 1'b1, 1'b0};
        tv[5]  = '{8'd4,  8'd127, 0, 502, 501, 1'b0, 1'b1};
        tv[6]  = '{8'd12, 8'd127, 0, 5,   4,   1'b0, 1'b1};
        tv[7]  = '{8'd7,  8'd127, 0, 788, 787, 1'b0, 1'b1};
        tv[8]  = '{8'd2,  8'd127, 1, 785, 784, 1'b1, 1'b1};
        tv[9]  = '{8'd8,  8'd127, 0, 1,   0,   1'b0, 1'b1};
        tv[10] = '{8'd15, 8'd127, 0, 1,   0,   1'b0, 1'b1};
        tv[11] = '{8'd6,  8'd90,  1, 785, 784, 1'b1, 1'b1};
        rst = 1'b1; sel = 1'b0; v = 1'b0; l = 1'b0; d = '0; th = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", rdy, 0);
        chk("rst_present", pres, 0);
        chk("rst_img_nonzero", img != '0, 0);
        chk("rst_label", lbo, 0);
        chk("rst_count", cnt_o, 0);
        chk("rst_err", ferr, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", rdy, 1);
        send_frame(8'd3, 8'd127, 0, 785, 784, 1'b1);
        chk("lat_before", pres, 0);
        @(posedge clk); #1;
        chk("lat_present", pres, 1);
        chk("lat_label_bits", img[9:0], 10'b0000001000);
        chk("lat_pix0", img[10], 1);
        chk("lat_pix1", img[11], 0);
        chk("lat_label_out", lbo, 3);
        chk("lat_count", cnt_o, 1);
        @(posedge clk); #1;
        chk("hold1_present", pres, 0);
        chk("hold1_img_nonzero", img != '0, 0);
        chk("hold1_label", lbo, 0);
        @(posedge clk); #1;
        chk("hold1_run", last_run, 1);
        exp_cnt = 1;
        for (int i = 0; i < 12; i++) begin
            send_frame(tv[i].lab, tv[i].th, tv[i].kind, tv[i].nb, tv[i].lastpos, tv[i].ok);
            if (tv[i].ok) exp_cnt++;
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("vec%0d_count", i), cnt_o, exp_cnt);
            chk($sformatf("vec%0d_err", i), ferr, tv[i].err);
            chk($sformatf("vec%0d_idle", i), pres, 0);
            chk($sformatf("vec%0d_img_nonzero", i), img != '0, 0);
        end
        chk("table_sb_left", q.size(), 0);
        rst = 1'b1; sel = 1'b1; q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_frame(8'd6, 8'd100, 1, 785, 784, 1'b1);
        send_frame(8'd2, 8'd30, 4, 785, 784, 1'b1);
        chk("b2b_ready_full", rdy, 0);
        chk("b2b_count_mid", cnt_o, 1);
        for (int w = 0; w < 3000 && pres; w++) begin
            @(posedge clk); #1;
        end
        @(negedge clk); #1;
        chk("b2b_run", last_run, 2 * P2);
        chk("b2b_count", cnt_o, 2);
        chk("b2b_err", ferr, 0);
        chk("b2b_sb_left", q.size(), 0);
        send_frame(8'd7, 8'd127, 0, 785, 784, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_present", pres, 1);
        chk("pre_rst_label", lbo, 7);
        #2 rst = 1'b1;
        #1;
        chk("async_img_nonzero", img != '0, 0);
        chk("async_present", pres, 0);
        chk("async_count", cnt_o, 0);
        chk("async_label", lbo, 0);
        chk("async_ready", rdy, 0);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", rdy, 1);
        send_frame(8'd9, 8'd10, 1, 785, 784, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_count", cnt_o, 1);
        chk("post_rst_label", lbo, 9);
        chk("post_rst_sb_left", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
